// File: rtl/alu_pkg.sv
// Shared opcode, ALU mux-select, latency-class and FSM encodings for the
// execute-stage ALU issue controller.
package alu_pkg;

    localparam int OP_CNT = 13;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_LSL = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;

    localparam logic [2:0] ALU_SEL_ADD   = 3'd0;
    localparam logic [2:0] ALU_SEL_MUL   = 3'd1;
    localparam logic [2:0] ALU_SEL_DIV   = 3'd2;
    localparam logic [2:0] ALU_SEL_MOV   = 3'd3;
    localparam logic [2:0] ALU_SEL_LOGIC = 3'd4;
    localparam logic [2:0] ALU_SEL_SHIFT = 3'd5;

    typedef enum logic [1:0] {
        LAT_ONE = 2'd0,
        LAT_MUL = 2'd1,
        LAT_DIV = 2'd2
    } lat_cls_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot ALU strobe, output mux select,
// latency class and illegal-opcode flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0]        opcode_i,
    output logic [OP_CNT-1:0] alu_op_o,
    output logic [2:0]        alu_sel_o,
    output lat_cls_t          lat_cls_o,
    output logic              illegal_o
);

    always_comb begin
        alu_sel_o = ALU_SEL_ADD;
        lat_cls_o = LAT_ONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_CMP: alu_sel_o = ALU_SEL_ADD;
            OP_MUL: begin
                alu_sel_o = ALU_SEL_MUL;
                lat_cls_o = LAT_MUL;
            end
            OP_DIV, OP_MOD: begin
                alu_sel_o = ALU_SEL_DIV;
                lat_cls_o = LAT_DIV;
            end
            OP_MOV:                 alu_sel_o = ALU_SEL_MOV;
            OP_AND, OP_OR, OP_NOT:  alu_sel_o = ALU_SEL_LOGIC;
            OP_LSL, OP_LSR, OP_ASR: alu_sel_o = ALU_SEL_SHIFT;
            default:                illegal_o = 1'b1;
        endcase
    end

    // Illegal opcodes must not strobe any ALU unit.
    assign alu_op_o = illegal_o ? '0 : (OP_CNT'(1) << opcode_i);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU sequencer: accepts one op, strobes the ALU for the op's
// latency, captures the result (and Eq/Gt flags for CMP), returns it on rsp_*.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_opcode,
    input  logic              req_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [OP_CNT-1:0] alu_op,
    output logic [2:0]        alu_sel,
    output logic              alu_imm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_eq,
    input  logic              alu_gt,
    output logic              flag_eq,
    output logic              flag_gt,
    output logic [1:0]        dbg_state
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // req_ready is high only in IDLE, rsp_valid only in RESP, and rsp_* hold
    // stable while rsp_valid is high and rsp_ready is low.

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cmp_q;
    logic [OP_CNT-1:0]   alu_op_q;
    logic [2:0]          alu_sel_q;
    logic                alu_imm_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                flag_eq_q;
    logic                flag_gt_q;

    logic [OP_CNT-1:0]   dec_op;
    logic [2:0]          dec_sel;
    lat_cls_t            dec_lat;
    logic                dec_illegal;
    logic [CNT_W-1:0]    cnt_d;

    alu_op_decode u_decode (
        .opcode_i  (req_opcode),
        .alu_op_o  (dec_op),
        .alu_sel_o (dec_sel),
        .lat_cls_o (dec_lat),
        .illegal_o (dec_illegal)
    );

    // Counter is loaded with lat-1 so the capture edge is the lat-th EXEC edge.
    always_comb begin
        cnt_d = '0;
        case (dec_lat)
            LAT_MUL: cnt_d = CNT_W'(MUL_LAT - 1);
            LAT_DIV: cnt_d = CNT_W'(DIV_LAT - 1);
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmp_q        <= 1'b0;
            alu_op_q     <= '0;
            alu_sel_q    <= '0;
            alu_imm_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            flag_eq_q    <= 1'b0;
            flag_gt_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmp_q <= (req_opcode == OP_CMP);
                        if (dec_illegal) begin
                            state_q      <= ST_RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            rsp_result_q <= '0;
                        end else begin
                            state_q   <= ST_EXEC;
                            rsp_err_q <= 1'b0;
                            cnt_q     <= cnt_d;
                            alu_op_q  <= dec_op;
                            alu_sel_q <= dec_sel;
                            alu_imm_q <= req_imm;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= alu_result;
                        alu_op_q     <= '0;
                        if (cmp_q) begin
                            flag_eq_q <= alu_eq;
                            flag_gt_q <= alu_gt;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign alu_op     = alu_op_q;
    assign alu_sel    = alu_sel_q;
    assign alu_imm    = alu_imm_q;
    assign flag_eq    = flag_eq_q;
    assign flag_gt    = flag_gt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, randomized ops against a
// spec-level model, plus reset-during-DIV sequence.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_opcode;
    logic              req_imm;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_err;
    logic [12:0]       alu_op;
    logic [2:0]        alu_sel;
    logic              alu_imm;
    logic [DATA_W-1:0] alu_result;
    logic              alu_eq;
    logic              alu_gt;
    logic              flag_eq;
    logic              flag_gt;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    logic m_eq = 1'b0;
    logic m_gt = 1'b0;

    alu_issue_ctrl #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_imm    (req_imm),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_op     (alu_op),
        .alu_sel    (alu_sel),
        .alu_imm    (alu_imm),
        .alu_result (alu_result),
        .alu_eq     (alu_eq),
        .alu_gt     (alu_gt),
        .flag_eq    (flag_eq),
        .flag_gt    (flag_gt),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        imm;
        logic [31:0] res;
        logic        eq;
        logic        gt;
        int          hold;
        logic [2:0]  exp_sel;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_sel(input logic [3:0] op);
        case (op)
            4'd2:             return 3'd1;
            4'd3, 4'd4:       return 3'd2;
            4'd9:             return 3'd3;
            4'd6, 4'd7, 4'd8: return 3'd4;
            4'd10, 4'd11, 4'd12: return 3'd5;
            default:          return 3'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        if (op > 4'd12) return 0;
        if (op == 4'd2) return MUL_LAT;
        if (op == 4'd3 || op == 4'd4) return DIV_LAT;
        return 1;
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns likewise.
    task automatic run_op(input logic [3:0] op, input logic imm, input logic [31:0] res,
                          input logic eq, input logic gt, input int hold,
                          input logic [2:0] exp_sel, input int exp_lat, input logic exp_err);
        logic [12:0] exp_op;
        logic [12:0] one;
        logic [31:0] exp_res;
        one    = 13'd1;
        exp_op = exp_err ? 13'd0 : (one << op);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        check("alu_op_idle", {51'd0, alu_op}, 64'd0);
        req_valid  = 1'b1;
        req_opcode = op;
        req_imm    = imm;
        alu_result = res;
        alu_eq     = eq;
        alu_gt     = gt;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_opcode = 4'($urandom_range(0, 15));
        req_imm    = ~imm;
        for (int k = 0; k < exp_lat; k++) begin
            check("exec_alu_op", {51'd0, alu_op}, {51'd0, exp_op});
            check("exec_alu_sel", {61'd0, alu_sel}, {61'd0, exp_sel});
            check("exec_alu_imm", {63'd0, alu_imm}, {63'd0, imm});
            check("exec_req_ready", {63'd0, req_ready}, 64'd0);
            check("exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            @(posedge clk); #1;
        end
        exp_res = exp_err ? 32'd0 : res;
        if (!exp_err && op == 4'd5) begin
            m_eq = eq;
            m_gt = gt;
        end
        alu_result = ~res;
        alu_eq     = ~eq;
        alu_gt     = ~gt;
        for (int k = 0; k <= hold; k++) begin
            check("resp_valid", {63'd0, rsp_valid}, 64'd1);
            check("resp_result", {32'd0, rsp_result}, {32'd0, exp_res});
            check("resp_err", {63'd0, rsp_err}, {63'd0, exp_err});
            check("resp_flags", {62'd0, flag_eq, flag_gt}, {62'd0, m_eq, m_gt});
            check("resp_alu_op", {51'd0, alu_op}, 64'd0);
            check("resp_req_ready", {63'd0, req_ready}, 64'd0);
            if (k == hold) rsp_ready = 1'b1;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        check("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("post_req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 4'd0;
        req_imm    = 1'b0;
        rsp_ready  = 1'b0;
        alu_result = '0;
        alu_eq     = 1'b0;
        alu_gt     = 1'b0;

        vecs[0]  = '{4'd0,  1'b0, 32'h0000_0007, 1'b0, 1'b0, 0, 3'd0, 1,       1'b0};
        vecs[1]  = '{4'd2,  1'b1, 32'h0000_1234, 1'b0, 1'b0, 1, 3'd1, MUL_LAT, 1'b0};
        vecs[2]  = '{4'd5,  1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 3'd0, 1,       1'b0};
        vecs[3]  = '{4'd0,  1'b1, 32'h0000_0005, 1'b0, 1'b1, 0, 3'd0, 1,       1'b0};
        vecs[4]  = '{4'd14, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 0, 3'd0, 0,       1'b1};
        vecs[5]  = '{4'd3,  1'b0, 32'hCAFE_0003, 1'b0, 1'b0, 4, 3'd2, DIV_LAT, 1'b0};
        vecs[6]  = '{4'd4,  1'b1, 32'h0000_0002, 1'b1, 1'b1, 2, 3'd2, DIV_LAT, 1'b0};
        vecs[7]  = '{4'd12, 1'b0, 32'hF000_0000, 1'b0, 1'b0, 0, 3'd5, 1,       1'b0};
        vecs[8]  = '{4'd8,  1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0, 1, 3'd4, 1,       1'b0};
        vecs[9]  = '{4'd9,  1'b1, 32'h0000_00AA, 1'b0, 1'b0, 0, 3'd3, 1,       1'b0};
        vecs[10] = '{4'd15, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 3, 3'd0, 0,       1'b1};
        vecs[11] = '{4'd5,  1'b1, 32'h0000_0000, 1'b0, 1'b1, 0, 3'd0, 1,       1'b0};

        #3;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        check("rst_alu_op", {51'd0, alu_op}, 64'd0);
        check("rst_alu_sel", {61'd0, alu_sel}, 64'd0);
        check("rst_alu_imm", {63'd0, alu_imm}, 64'd0);
        check("rst_flags", {62'd0, flag_eq, flag_gt}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].imm, vecs[i].res, vecs[i].eq, vecs[i].gt, vecs[i].hold,
                   vecs[i].exp_sel, vecs[i].exp_lat, vecs[i].exp_err);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            run_op(op, 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), model_sel(op), model_lat(op), op > 4'd12);
        end

        // Set both flags, then reset in the middle of a DIV.
        run_op(4'd5, 1'b0, 32'd0, 1'b1, 1'b1, 0, 3'd0, 1, 1'b0);
        req_valid  = 1'b1;
        req_opcode = 4'd3;
        alu_result = 32'h5555_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        m_eq = 1'b0;
        m_gt = 1'b0;
        #1;
        check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("midrst_alu_op", {51'd0, alu_op}, 64'd0);
        check("midrst_flags", {62'd0, flag_eq, flag_gt}, 64'd0);
        check("midrst_rsp_result", {32'd0, rsp_result}, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        #1 rst_n = 1'b1;
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        run_op(4'd0, 1'b0, 32'h0000_0042, 1'b0, 1'b0, 0, 3'd0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
